// File: rtl/timestamp_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : timestamp_capture_if
// Brief    : Avalon-MM slave register bus for timestamp_capture.
// Revision : 1.0 - initial release
// ============================================================================
interface timestamp_capture_if;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );
endinterface : timestamp_capture_if
`default_nettype wire

// File: rtl/timestamp_capture.sv
`default_nettype none
// ============================================================================
// Module   : timestamp_capture
// Brief    : Captures count_in on edges of an async event into a FIFO read
//            over Avalon-MM. Optional macro TSCAP_IRQ_EN adds the irq output.
// Revision : 1.0 - initial release
// ============================================================================
module timestamp_capture #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] count_in,
  input  logic        event_in,
  timestamp_capture_if.slave bus
`ifdef TSCAP_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int             c_aw         = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0]  c_full       = (c_aw + 1)'(DEPTH);
  localparam logic [3:0]     c_addr_data  = 4'd0;
  localparam logic [3:0]     c_addr_stat  = 4'd1;
  localparam logic [3:0]     c_addr_ctrl  = 4'd2;
  localparam logic [3:0]     c_addr_clear = 4'd3;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_edge_q;
  logic              r_enable;
  logic              r_edge_sel;
  logic              r_overflow;
  logic [c_aw-1:0]   r_wptr;
  logic [c_aw-1:0]   r_rptr;
  logic [c_aw:0]     r_count;
  logic [31:0]       r_mem [DEPTH];

  logic              w_irq_en;
  logic              w_empty;
  logic              w_full;
  logic              w_edge;
  logic              w_push_req;
  logic              w_pop;
  logic              w_clear;
  logic              w_push;
  logic              w_ovf_set;
  logic [7:0]        w_occ;
  logic [31:0]       w_status;
  logic [31:0]       w_control;
  logic [31:0]       w_readdata;
  logic              w_unused;

  // Edge detector runs every cycle so toggling enable never fabricates an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_edge_q <= 1'b0;
    end else begin
      r_sync1  <= event_in;
      r_sync2  <= r_sync1;
      r_edge_q <= r_sync2;
    end
  end

  assign w_edge     = r_edge_sel ? (~r_sync2 & r_edge_q) : (r_sync2 & ~r_edge_q);
  assign w_push_req = r_enable & w_edge;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_full);
  assign w_pop      = bus.read  & (bus.address == c_addr_data) & ~w_empty;
  assign w_clear    = bus.write & (bus.address == c_addr_clear);
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  assign w_push     = w_push_req & ~w_clear & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & ~w_clear & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable   <= 1'b0;
      r_edge_sel <= 1'b0;
    end else if (bus.write && bus.address == c_addr_ctrl) begin
      r_enable   <= bus.writedata[0];
      r_edge_sel <= bus.writedata[1];
    end
  end

`ifdef TSCAP_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (bus.write && bus.address == c_addr_ctrl)
        r_irq_en <= bus.writedata[2];
      r_irq <= r_irq_en & (~w_empty | r_overflow);
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
      if (w_ovf_set)
        r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= count_in;
  end

  assign w_occ     = 8'(r_count);
  assign w_status  = {16'd0, w_occ, 5'd0, r_overflow, w_full, w_empty};
  assign w_control = {29'd0, w_irq_en, r_edge_sel, r_enable};

  always_comb begin
    w_readdata = 32'd0;
    if (bus.read) begin
      case (bus.address)
        c_addr_data: w_readdata = w_empty ? 32'd0 : r_mem[r_rptr];
        c_addr_stat: w_readdata = w_status;
        c_addr_ctrl: w_readdata = w_control;
        default:     w_readdata = 32'd0;
      endcase
    end
  end

  assign bus.readdata = w_readdata;
  assign w_unused     = ^bus.writedata[31:2];

endmodule : timestamp_capture
`default_nettype wire
